// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined processor: datapath widths,
// reset/flush encodings and the stall-control encoding used by the hazard
// unit, the fetch stage and the ID/EX stage.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;
  localparam int CNT_W   = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;
  localparam logic [PC_W-1:0]    RESET_PC  = 8'h00;

  // Stall-control encoding: a write enable of 1 lets a register advance,
  // and haz_mux_con = 0 turns the ID/EX load into a bubble.
  localparam logic WR_ADVANCE = 1'b1;
  localparam logic WR_HOLD    = 1'b0;
  localparam logic HAZ_PASS   = 1'b1;
  localparam logic HAZ_BUBBLE = 1'b0;

  // What the front end does on a given edge.
  typedef enum logic [1:0] {
    FETCH_ADVANCE = 2'd0,
    FETCH_STALL   = 2'd1,
    FETCH_FLUSH   = 2'd2,
    FETCH_DROP    = 2'd3
  } fetch_action_e;

  // Classify one edge. A flush beats any stall request because the branch
  // is older than the stalled pair; PC moving while IF/ID holds loses an
  // instruction and is reported as a drop.
  function automatic fetch_action_e classify(input logic pc_write,
                                             input logic ifid_write,
                                             input logic branch_taken);
    fetch_action_e act;
    if (branch_taken)
      act = FETCH_FLUSH;
    else if (ifid_write == WR_HOLD && pc_write == WR_ADVANCE)
      act = FETCH_DROP;
    else if (ifid_write == WR_HOLD)
      act = FETCH_STALL;
    else
      act = FETCH_ADVANCE;
    return act;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of hazard controls, branch redirect, instruction memory port and
// IF/ID outputs of the fetch stage. The slave side is the fetch stage; the
// master side is whoever drives the controls and serves instruction memory.
interface fetch_stage_if #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int CNT_W   = cpu_pkg::CNT_W
) ();

  logic               pc_write;
  logic               ifid_write;
  logic               haz_mux_con;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;
  logic               ifid_valid;
  logic               idex_bubble;
  logic [CNT_W-1:0]   stall_count;
  logic               protocol_err;

  modport master (
    output pc_write, ifid_write, haz_mux_con, branch_taken, branch_target,
    output imem_data,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, idex_bubble,
    input  stall_count, protocol_err
  );

  modport slave (
    input  pc_write, ifid_write, haz_mux_con, branch_taken, branch_target,
    input  imem_data,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, idex_bubble,
    output stall_count, protocol_err
  );

endinterface

// File: rtl/fetch_stage_pipe_reg.sv
// Generic pipeline register field: synchronous reset value, flush load and
// enable. Priority on each edge is rst > flush > en > hold.
module pipe_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  input  logic [W-1:0] flush_val,
  output logic [W-1:0] q
);
  import cpu_pkg::*;

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Next value: flush overrides the enable, otherwise load or hold.
  always_comb begin
    data_d = data_q;
    if (flush)
      data_d = flush_val;
    else if (en == WR_ADVANCE)
      data_d = d;
  end

  // Register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst)
      data_q <= RST_VAL;
    else
      data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, IF/ID register (instr, pc, valid), ID/EX bubble
// select, a saturating stall counter and a sticky protocol-error flag.
module fetch_stage #(
  parameter int                   PC_W      = cpu_pkg::PC_W,
  parameter int                   INSTR_W   = cpu_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter logic [PC_W-1:0]      RESET_PC  = cpu_pkg::RESET_PC,
  parameter int                   CNT_W     = cpu_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);
  import cpu_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;
  logic             protocol_err_q;
  logic             protocol_err_d;
  fetch_action_e    action;

  assign action = classify(bus.pc_write, bus.ifid_write, bus.branch_taken);

  // Next PC, stall count and error flag from this edge's action.
  always_comb begin
    pc_d           = pc_q;
    stall_count_d  = stall_count_q;
    protocol_err_d = protocol_err_q;

    if (action == FETCH_FLUSH)
      pc_d = bus.branch_target;
    else if (bus.pc_write == WR_ADVANCE)
      pc_d = pc_q + PC_W'(1);

    // Both plain stalls and drops hold IF/ID, so both count as stalled.
    if ((action == FETCH_STALL || action == FETCH_DROP) && stall_count_q != CNT_MAX)
      stall_count_d = stall_count_q + CNT_W'(1);

    if (action == FETCH_DROP)
      protocol_err_d = 1'b1;
  end

  // PC, counter and sticky flag; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      stall_count_q  <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      stall_count_q  <= stall_count_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // IF/ID fields. A flush records the PC being squashed in ifid_pc.
  pipe_reg #(.W(INSTR_W), .RST_VAL(NOP_INSTR)) u_ifid_instr (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.ifid_write),
    .flush     (bus.branch_taken),
    .d         (bus.imem_data),
    .flush_val (NOP_INSTR),
    .q         (bus.ifid_instr)
  );

  pipe_reg #(.W(PC_W), .RST_VAL('0)) u_ifid_pc (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.ifid_write),
    .flush     (bus.branch_taken),
    .d         (pc_q),
    .flush_val (pc_q),
    .q         (bus.ifid_pc)
  );

  pipe_reg #(.W(1), .RST_VAL(1'b0)) u_ifid_valid (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.ifid_write),
    .flush     (bus.branch_taken),
    .d         (1'b1),
    .flush_val (1'b0),
    .q         (bus.ifid_valid)
  );

  assign bus.imem_addr    = pc_q;
  assign bus.idex_bubble  = rst | (bus.haz_mux_con == HAZ_BUBBLE) | (bus.ifid_write == WR_HOLD);
  assign bus.stall_count  = stall_count_q;
  assign bus.protocol_err = protocol_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one full-width instance walks through
// reset, free run, load-use stall, branch flush, PC wrap, illegal combo and
// mid-stall reset; a second instance with a 2-bit counter checks saturation.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.PC_W(8), .INSTR_W(8), .CNT_W(16)) ifa ();
  fetch_stage_if #(.PC_W(8), .INSTR_W(8), .CNT_W(2))  ifb ();

  // Instruction memory model: data = addr ^ A5.
  assign ifa.imem_data = ifa.imem_addr ^ 8'hA5;
  assign ifb.imem_data = ifb.imem_addr ^ 8'hA5;

  fetch_stage #(.PC_W(8), .INSTR_W(8), .NOP_INSTR(8'h00), .RESET_PC(8'h00), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  fetch_stage #(.PC_W(8), .INSTR_W(8), .NOP_INSTR(8'h00), .RESET_PC(8'h00), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_a(input logic pw, input logic iw, input logic hz,
                        input logic br, input logic [7:0] tgt);
    ifa.pc_write      = pw;
    ifa.ifid_write    = iw;
    ifa.haz_mux_con   = hz;
    ifa.branch_taken  = br;
    ifa.branch_target = tgt;
  endtask

  task automatic check_ifid(input string tag, input logic [7:0] pc, input logic [7:0] instr,
                            input logic [7:0] ipc, input logic valid);
    check({tag, ".pc"},    32'(ifa.imem_addr),  32'(pc));
    check({tag, ".instr"}, 32'(ifa.ifid_instr), 32'(instr));
    check({tag, ".ifpc"},  32'(ifa.ifid_pc),    32'(ipc));
    check({tag, ".valid"}, 32'(ifa.ifid_valid), 32'(valid));
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ctrl_a(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    ifb.pc_write = 1'b1; ifb.ifid_write = 1'b1; ifb.haz_mux_con = 1'b1;
    ifb.branch_taken = 1'b0; ifb.branch_target = 8'h00;
    #1;
    check("rst_bubble", 32'(ifa.idex_bubble), 32'd1);

    // Reset state
    step();
    check_ifid("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    check("reset.cnt", 32'(ifa.stall_count), 32'd0);
    check("reset.err", 32'(ifa.protocol_err), 32'd0);

    // Free run
    rst_a = 1'b0;
    #1;
    check("run_bubble", 32'(ifa.idex_bubble), 32'd0);
    step(); check_ifid("run1", 8'h01, 8'hA5, 8'h00, 1'b1);
    step(); check_ifid("run2", 8'h02, 8'hA4, 8'h01, 1'b1);
    step(); check_ifid("run3", 8'h03, 8'hA7, 8'h02, 1'b1);
    step(); step();
    check_ifid("run5", 8'h05, 8'hA1, 8'h04, 1'b1);

    // Load-use stall for two cycles at pc = 05
    ctrl_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    check("stall_bub0", 32'(ifa.idex_bubble), 32'd1);
    step();
    check_ifid("stall1", 8'h05, 8'hA1, 8'h04, 1'b1);
    check("stall1.cnt", 32'(ifa.stall_count), 32'd1);
    check("stall_bub1", 32'(ifa.idex_bubble), 32'd1);
    step();
    check_ifid("stall2", 8'h05, 8'hA1, 8'h04, 1'b1);
    check("stall2.cnt", 32'(ifa.stall_count), 32'd2);
    ctrl_a(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    #1;
    check("resume_bub", 32'(ifa.idex_bubble), 32'd0);
    step();
    check_ifid("resume", 8'h06, 8'hA0, 8'h05, 1'b1);
    check("resume.cnt", 32'(ifa.stall_count), 32'd2);

    // Branch during stall
    ctrl_a(1'b0, 1'b0, 1'b0, 1'b1, 8'h40);
    step();
    check_ifid("branch", 8'h40, 8'h00, 8'h06, 1'b0);
    check("branch.cnt", 32'(ifa.stall_count), 32'd2);
    check("branch.err", 32'(ifa.protocol_err), 32'd0);

    // PC wrap: branch to FF, then advance
    ctrl_a(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    step();
    check("tgt_ff.pc", 32'(ifa.imem_addr), 32'h0FF);
    ctrl_a(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    check_ifid("wrap", 8'h00, 8'h5A, 8'hFF, 1'b1);

    // Illegal combo: PC advances while IF/ID holds
    ctrl_a(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    step();
    check_ifid("drop", 8'h01, 8'h5A, 8'hFF, 1'b1);
    check("drop.err", 32'(ifa.protocol_err), 32'd1);
    check("drop.cnt", 32'(ifa.stall_count), 32'd3);
    ctrl_a(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    check("sticky.err", 32'(ifa.protocol_err), 32'd1);
    check("sticky.pc", 32'(ifa.imem_addr), 32'h02);

    // Stall until the counter reaches 7, then reset mid-stall
    ctrl_a(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(); step(); step(); step();
    check("pre_rst.cnt", 32'(ifa.stall_count), 32'd7);
    check("pre_rst.pc", 32'(ifa.imem_addr), 32'h02);
    ctrl_a(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    rst_a = 1'b1;
    #1;
    check("rst_bub2", 32'(ifa.idex_bubble), 32'd1);
    step();
    check_ifid("midrst", 8'h00, 8'h00, 8'h00, 1'b0);
    check("midrst.cnt", 32'(ifa.stall_count), 32'd0);
    check("midrst.err", 32'(ifa.protocol_err), 32'd0);

    // Saturation on the 2-bit counter instance
    check("sat.rst", 32'(ifb.stall_count), 32'd0);
    rst_b = 1'b0;
    ifb.pc_write = 1'b0; ifb.ifid_write = 1'b0; ifb.haz_mux_con = 1'b0;
    step(); check("sat1", 32'(ifb.stall_count), 32'd1);
    step(); check("sat2", 32'(ifb.stall_count), 32'd2);
    step(); check("sat3", 32'(ifb.stall_count), 32'd3);
    step(); check("sat4", 32'(ifb.stall_count), 32'd3);
    step(); check("sat5", 32'(ifb.stall_count), 32'd3);
    check("sat.err", 32'(ifb.protocol_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
